imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter SHAMT_ZEXT, default 1; 1 = shift-immediate ops emit zero-extended shamt.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_ready  output  1  stage can accept; registered output.
REQ-008 SHALL have port in_instr  input  32  instruction word.
REQ-009 SHALL have port in_pc  input  XLEN  address of in_instr.
REQ-010 SHALL have port out_valid  output  1  decoded entry present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_instr  output  32  instruction passed through.
REQ-013 SHALL have port out_imm  output  XLEN  unified immediate.
REQ-014 SHALL have port out_imm_type  output  3  enum NONE/I/S/B/U/J/SHAMT.
REQ-015 SHALL have port out_target  output  XLEN  pc+imm for B, J, AUIPC; else 0.
REQ-016 SHALL have port out_illegal  output  1  unsupported encoding.

Function
REQ-017 SHALL transfer in on in_valid&in_ready, out on out_valid&out_ready.
REQ-018 SHALL present a decoded entry at out_* exactly 1 cycle after its in-transfer when empty.
REQ-019 SHALL buffer up to 2 entries (output register + skid register); in_ready = skid empty.
REQ-020 SHALL preserve entry order; never drop or duplicate under any out_ready pattern.
REQ-021 SHALL hold out_* stable while out_valid & !out_ready.
REQ-022 SHALL sustain 1 transfer/cycle when out_ready held high.
REQ-023 SHALL handle simultaneous in- and out-transfer at occupancy 1 or 2 without stalling.
REQ-024 SHALL decode, with sign-extension from instr[31] to XLEN: I for 0010011, 0000011, 1100111; S for 0100011; B for 1100011; U for 0110111, 0010111; J for 1101111.
REQ-025 SHALL for U-type with XLEN=64 sign-extend {instr[31:12],12'b0} from bit 31.
REQ-026 SHALL when SHAMT_ZEXT=1 and opcode 0010011 with funct3 001/101 emit SHAMT type, imm = zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
REQ-027 SHALL emit NONE, imm 0, illegal 0 for 0110011, 0111011, 0001111, 1110011.
REQ-028 SHALL emit NONE, imm 0, illegal 1 for any other opcode or instr[1:0]!=2'b11.
REQ-029 SHALL compute out_target = in_pc + imm modulo 2^XLEN for B, J, AUIPC only.
REQ-030 SHALL on flush clear occupancy next cycle, out_valid=0, in_ready=1; an in-transfer in the flush cycle is discarded.

Reset
REQ-031 SHALL while rst high force out_valid=0, in_ready=0, all data outputs 0, both buffers empty.
REQ-032 SHALL assert in_ready in the first cycle after rst deasserts.
REQ-033 SHALL discard in-flight entries on rst mid-operation; rst priority over flush.

Structure
REQ-034 SHALL place imm_type_e enum and opcode constants in shared package riscv_pkg.
REQ-035 SHALL factor combinational decode into sub-module imm_decode (instr,pc -> imm,type,target,illegal), instantiated once at input.

Verification
REQ-036 SHALL test 0xFFF00093 (addi -1), XLEN=32 -> imm 0xFFFFFFFF, type I, illegal 0, 1-cycle latency.
REQ-037 SHALL test 0xFE000EE3 at pc 0x100 -> type B, imm 0xFFFFFFFC, target 0x000000FC.
REQ-038 SHALL test 0x001000EF at pc 0x1000 -> type J, imm 0x800, target 0x1800; 0x123452B7 -> U, imm 0x12345000.
REQ-039 SHALL test 3 back-to-back pushes with out_ready low 3 cycles -> in_ready low after 2nd, all 3 emerge in order.
REQ-040 SHALL test 0x00000000 -> illegal 1, imm 0, type NONE; flush at occupancy 2 -> out_valid 0 next cycle, in_ready 1.
REQ-041 SHALL test XLEN=64, 0x800002B7 -> imm 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: immediate-format enum and the base opcodes
// the immediate decoder recognises.
package riscv_pkg;

   typedef enum logic [2:0] {
      IMM_NONE  = 3'd0,
      IMM_I     = 3'd1,
      IMM_S     = 3'd2,
      IMM_B     = 3'd3,
      IMM_U     = 3'd4,
      IMM_J     = 3'd5,
      IMM_SHAMT = 3'd6
   } imm_type_e;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_OP_32    = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: unified sign-extended immediate, its
// format, the pc-relative target for branches/jumps/auipc, and an illegal flag.
module imm_decode
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit SHAMT_ZEXT = 1'b1
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] imm,
   output imm_type_e       imm_type,
   output logic [XLEN-1:0] target,
   output logic            illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm32;
   logic        use_target;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   always_comb begin
      imm32      = 32'd0;
      imm_type   = IMM_NONE;
      illegal    = 1'b0;
      use_target = 1'b0;
      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (opcode)
            OPC_OP_IMM: begin
               if (SHAMT_ZEXT && (funct3 == F3_SLL || funct3 == F3_SRX)) begin
                  imm_type = IMM_SHAMT;
               end else begin
                  imm_type = IMM_I;
                  imm32    = {{20{instr[31]}}, instr[31:20]};
               end
            end
            OPC_LOAD, OPC_JALR: begin
               imm_type = IMM_I;
               imm32    = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
               imm_type = IMM_S;
               imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
               imm_type   = IMM_B;
               use_target = 1'b1;
               imm32      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI: begin
               imm_type = IMM_U;
               imm32    = {instr[31:12], 12'd0};
            end
            OPC_AUIPC: begin
               imm_type   = IMM_U;
               use_target = 1'b1;
               imm32      = {instr[31:12], 12'd0};
            end
            OPC_JAL: begin
               imm_type   = IMM_J;
               use_target = 1'b1;
               imm32      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP, OPC_OP_32, OPC_MISC_MEM, OPC_SYSTEM: begin
               imm_type = IMM_NONE;
            end
            default: illegal = 1'b1;
         endcase
      end
   end

   // Shift amounts are zero-extended; every other format sign-extends from bit 31.
   always_comb begin
      if (imm_type == IMM_SHAMT) begin
         imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      end else begin
         imm = XLEN'($signed(imm32));
      end
      target = use_target ? (pc + imm) : '0;
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Pipeline stage: decodes immediates at the input and buffers up to two
// entries (output register plus skid register) with a registered in_ready.
module imm_decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit SHAMT_ZEXT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_imm,
   output imm_type_e       out_imm_type,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   logic [XLEN-1:0] dec_imm;
   imm_type_e       dec_type;
   logic [XLEN-1:0] dec_target;
   logic            dec_illegal;

   imm_decode #(
      .XLEN       (XLEN),
      .SHAMT_ZEXT (SHAMT_ZEXT)
   ) u_dec (
      .instr    (in_instr),
      .pc       (in_pc),
      .imm      (dec_imm),
      .imm_type (dec_type),
      .target   (dec_target),
      .illegal  (dec_illegal)
   );

   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [31:0]     out_instr_q, out_instr_d;
   logic [XLEN-1:0] out_imm_q, out_imm_d;
   imm_type_e       out_type_q, out_type_d;
   logic [XLEN-1:0] out_target_q, out_target_d;
   logic            out_illegal_q, out_illegal_d;
   logic            skid_valid_q, skid_valid_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] skid_imm_q, skid_imm_d;
   imm_type_e       skid_type_q, skid_type_d;
   logic [XLEN-1:0] skid_target_q, skid_target_d;
   logic            skid_illegal_q, skid_illegal_d;

   logic in_xfer;
   logic out_free;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_free = ~out_valid_q | out_ready;

   always_comb begin
      out_valid_d    = out_valid_q;
      out_instr_d    = out_instr_q;
      out_imm_d      = out_imm_q;
      out_type_d     = out_type_q;
      out_target_d   = out_target_q;
      out_illegal_d  = out_illegal_q;
      skid_valid_d   = skid_valid_q;
      skid_instr_d   = skid_instr_q;
      skid_imm_d     = skid_imm_q;
      skid_type_d    = skid_type_q;
      skid_target_d  = skid_target_q;
      skid_illegal_d = skid_illegal_q;

      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         // Skid holds the older entry, so it moves forward before new input.
         if (skid_valid_q) begin
            out_valid_d   = 1'b1;
            out_instr_d   = skid_instr_q;
            out_imm_d     = skid_imm_q;
            out_type_d    = skid_type_q;
            out_target_d  = skid_target_q;
            out_illegal_d = skid_illegal_q;
            skid_valid_d  = 1'b0;
         end else begin
            out_valid_d = in_xfer;
            if (in_xfer) begin
               out_instr_d   = in_instr;
               out_imm_d     = dec_imm;
               out_type_d    = dec_type;
               out_target_d  = dec_target;
               out_illegal_d = dec_illegal;
            end
         end
      end else if (in_xfer) begin
         skid_valid_d   = 1'b1;
         skid_instr_d   = in_instr;
         skid_imm_d     = dec_imm;
         skid_type_d    = dec_type;
         skid_target_d  = dec_target;
         skid_illegal_d = dec_illegal;
      end

      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         out_instr_q    <= '0;
         out_imm_q      <= '0;
         out_type_q     <= IMM_NONE;
         out_target_q   <= '0;
         out_illegal_q  <= 1'b0;
         skid_valid_q   <= 1'b0;
         skid_instr_q   <= '0;
         skid_imm_q     <= '0;
         skid_type_q    <= IMM_NONE;
         skid_target_q  <= '0;
         skid_illegal_q <= 1'b0;
      end else begin
         in_ready_q     <= in_ready_d;
         out_valid_q    <= out_valid_d;
         out_instr_q    <= out_instr_d;
         out_imm_q      <= out_imm_d;
         out_type_q     <= out_type_d;
         out_target_q   <= out_target_d;
         out_illegal_q  <= out_illegal_d;
         skid_valid_q   <= skid_valid_d;
         skid_instr_q   <= skid_instr_d;
         skid_imm_q     <= skid_imm_d;
         skid_type_q    <= skid_type_d;
         skid_target_q  <= skid_target_d;
         skid_illegal_q <= skid_illegal_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_instr    = out_instr_q;
   assign out_imm      = out_imm_q;
   assign out_imm_type = out_type_q;
   assign out_target   = out_target_q;
   assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: one XLEN=32 and one XLEN=64 instance,
// hand-computed expected immediates, targets and handshake behaviour.
module tb_imm_decode_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_instr, out_imm, out_target;
   logic [2:0]  out_imm_type;

   logic        flush64, in_valid64, out_ready64;
   logic [31:0] in_instr64;
   logic [63:0] in_pc64;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [31:0] out_instr64;
   logic [63:0] out_imm64, out_target64;
   logic [2:0]  out_imm_type64;

   imm_decode_stage #(.XLEN(32), .SHAMT_ZEXT(1'b1)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_imm(out_imm), .out_imm_type(out_imm_type), .out_target(out_target),
      .out_illegal(out_illegal)
   );

   imm_decode_stage #(.XLEN(64), .SHAMT_ZEXT(1'b1)) dut64 (
      .clk(clk), .rst(rst), .flush(flush64),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
      .out_valid(out_valid64), .out_ready(out_ready64), .out_instr(out_instr64),
      .out_imm(out_imm64), .out_imm_type(out_imm_type64), .out_target(out_target64),
      .out_illegal(out_illegal64)
   );

   localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                          T_U = 3'd4, T_J = 3'd5, T_SHAMT = 3'd6;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // One-cycle push into dut32 with out_ready high; checks the decoded entry a cycle later.
   task automatic push32(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] e_imm, input logic [2:0] e_type,
                         input logic [31:0] e_tgt, input logic e_ill);
      in_valid = 1'b1; in_instr = instr; in_pc = pc;
      step();
      in_valid = 1'b0;
      check_val({tag, ".valid"}, 64'(out_valid), 64'd1);
      check_val({tag, ".instr"}, 64'(out_instr), 64'(instr));
      check_val({tag, ".imm"}, 64'(out_imm), 64'(e_imm));
      check_val({tag, ".type"}, 64'(out_imm_type), 64'(e_type));
      check_val({tag, ".target"}, 64'(out_target), 64'(e_tgt));
      check_val({tag, ".illegal"}, 64'(out_illegal), 64'(e_ill));
      $display("txn %s instr=0x%08h imm=0x%08h type=%0d target=0x%08h ill=%0b",
               tag, instr, out_imm, out_imm_type, out_target, out_illegal);
   endtask

   task automatic push64(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                         input logic [63:0] e_imm, input logic [2:0] e_type,
                         input logic [63:0] e_tgt);
      in_valid64 = 1'b1; in_instr64 = instr; in_pc64 = pc;
      step();
      in_valid64 = 1'b0;
      check_val({tag, ".valid"}, 64'(out_valid64), 64'd1);
      check_val({tag, ".imm"}, out_imm64, e_imm);
      check_val({tag, ".type"}, 64'(out_imm_type64), 64'(e_type));
      check_val({tag, ".target"}, out_target64, e_tgt);
      $display("txn %s instr=0x%08h imm=0x%016h type=%0d", tag, instr, out_imm64, out_imm_type64);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
      flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1; in_instr64 = '0; in_pc64 = '0;
      step(); step();
      check_val("rst.out_valid", 64'(out_valid), 64'd0);
      check_val("rst.in_ready", 64'(in_ready), 64'd0);
      check_val("rst.out_imm", 64'(out_imm), 64'd0);
      check_val("rst.out_instr", 64'(out_instr), 64'd0);
      check_val("rst.in_ready64", 64'(in_ready64), 64'd0);
      rst = 1'b0;
      step();
      check_val("post_rst.in_ready", 64'(in_ready), 64'd1);
      check_val("post_rst.out_valid", 64'(out_valid), 64'd0);

      out_ready = 1'b1;
      push32("addi_m1", 32'hFFF00093, 32'h0,    32'hFFFFFFFF, T_I,     32'h0,        1'b0);
      push32("beq_m4",  32'hFE000EE3, 32'h100,  32'hFFFFFFFC, T_B,     32'h000000FC, 1'b0);
      push32("jal_800", 32'h001000EF, 32'h1000, 32'h00000800, T_J,     32'h00001800, 1'b0);
      push32("lui",     32'h123452B7, 32'h40,   32'h12345000, T_U,     32'h0,        1'b0);
      push32("auipc",   32'h00001297, 32'h200,  32'h00001000, T_U,     32'h00001200, 1'b0);
      push32("sw_m4",   32'hFE112E23, 32'h0,    32'hFFFFFFFC, T_S,     32'h0,        1'b0);
      push32("slli3",   32'h00309093, 32'h0,    32'h00000003, T_SHAMT, 32'h0,        1'b0);
      push32("srai3",   32'h4030D093, 32'h0,    32'h00000003, T_SHAMT, 32'h0,        1'b0);
      push32("add",     32'h002081B3, 32'h0,    32'h0,        T_NONE,  32'h0,        1'b0);
      push32("zero",    32'h00000000, 32'h0,    32'h0,        T_NONE,  32'h0,        1'b1);
      push32("badopc",  32'h0000007F, 32'h0,    32'h0,        T_NONE,  32'h0,        1'b1);
      step();
      check_val("drain.out_valid", 64'(out_valid), 64'd0);

      // Backpressure: three pushes while out_ready is low for three edges.
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00100093; in_pc = '0;
      step();
      check_val("bp.a_out", 64'(out_instr), 64'h00100093);
      check_val("bp.rdy_after1", 64'(in_ready), 64'd1);
      in_instr = 32'h00200093;
      step();
      check_val("bp.rdy_after2", 64'(in_ready), 64'd0);
      check_val("bp.a_hold1", 64'(out_instr), 64'h00100093);
      in_instr = 32'h00300093;
      step();
      check_val("bp.rdy_full", 64'(in_ready), 64'd0);
      check_val("bp.a_hold2", 64'(out_instr), 64'h00100093);
      check_val("bp.a_imm_hold", 64'(out_imm), 64'h1);
      out_ready = 1'b1;
      step();
      check_val("bp.b_out", 64'(out_instr), 64'h00200093);
      check_val("bp.b_imm", 64'(out_imm), 64'h2);
      check_val("bp.rdy_reopen", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check_val("bp.c_out", 64'(out_instr), 64'h00300093);
      check_val("bp.c_valid", 64'(out_valid), 64'd1);
      $display("txn backpressure a/b/c order observed");
      step();
      check_val("bp.empty", 64'(out_valid), 64'd0);

      // Flush at occupancy 2, with an offered input that must be discarded.
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00400093;
      step();
      in_instr = 32'h00500093;
      step();
      check_val("fl.full", 64'(in_ready), 64'd0);
      flush = 1'b1; in_instr = 32'h00600093;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check_val("fl.out_valid", 64'(out_valid), 64'd0);
      check_val("fl.in_ready", 64'(in_ready), 64'd1);
      step();
      check_val("fl.stays_empty", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      push32("after_fl", 32'h00700093, 32'h0, 32'h7, T_I, 32'h0, 1'b0);
      $display("txn flush at occupancy 2");

      // Reset mid-operation discards the buffered entries.
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00800093;
      step();
      in_instr = 32'h00900093;
      step();
      in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
      step();
      check_val("mrst.out_valid", 64'(out_valid), 64'd0);
      check_val("mrst.in_ready", 64'(in_ready), 64'd0);
      check_val("mrst.out_imm", 64'(out_imm), 64'd0);
      rst = 1'b0; flush = 1'b0;
      step();
      check_val("mrst.in_ready_back", 64'(in_ready), 64'd1);
      check_val("mrst.empty", 64'(out_valid), 64'd0);
      $display("txn reset mid-operation");

      push64("lui64_neg",  32'h800002B7, 64'h0,    64'hFFFFFFFF80000000, T_U,     64'h0);
      push64("slli64_63",  32'h03F09093, 64'h0,    64'h000000000000003F, T_SHAMT, 64'h0);
      push64("beq64_m4",   32'hFE000EE3, 64'h100,  64'hFFFFFFFFFFFFFFFC, T_B,     64'hFC);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
